// File: rtl/tag_pkg.sv
// Shared state encodings and front-panel defaults for the tag RX sequencer.
package tag_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StQual  = 3'd1,
    StArmed = 3'd2,
    StRun   = 3'd3,
    StDone  = 3'd4
  } rx_state_e;

  localparam logic [11:0] SyncMaskDefault = 12'h044;
  localparam logic [11:0] FpGpioDdr       = 12'h00F;

endpackage

// File: rtl/tag_rx_seq_ctrl_if.sv
// Sequencer outputs towards the shared DDS and the RX baseband path.
interface tag_rx_seq_ctrl_if #(
  parameter int unsigned PHASE_WIDTH = 24,
  parameter int unsigned NSYMB_WIDTH = 16
);
  logic [PHASE_WIDTH-1:0] ph;
  logic [PHASE_WIDTH-1:0] phinc;
  logic [NSYMB_WIDTH-1:0] symbN;
  logic [2:0]             rx_state;
  logic                   rx_sync_en;
  logic                   rx_trig;
  logic                   rx_valid;
  logic                   rx_out_mux;
  logic                   frame_done;
  logic                   sync_err;

  modport master (
    output ph, phinc, symbN, rx_state, rx_sync_en, rx_trig, rx_valid, rx_out_mux,
           frame_done, sync_err
  );

  modport slave (
    input ph, phinc, symbN, rx_state, rx_sync_en, rx_trig, rx_valid, rx_out_mux,
          frame_done, sync_err
  );
endinterface

// File: rtl/gpio_sync.sv
// Two-flop synchroniser for the asynchronous front-panel GPIO bus.
module gpio_sync #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_s1,
  output logic [WIDTH-1:0] gpio_s
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= gpio_in;
      sync_q <= meta_q;
    end
  end

  assign gpio_s1 = meta_q;
  assign gpio_s  = sync_q;
endmodule

// File: rtl/tag_rx_seq_ctrl.sv
// Tag RX sequencer: qualifies the GPIO sync pulse, then steps a frequency-hopped
// symbol frame through the DDS phase increment.
module tag_rx_seq_ctrl
  import tag_pkg::*;
#(
  parameter int unsigned          PHASE_WIDTH = 24,
  parameter int unsigned          NSIG_WIDTH  = 16,
  parameter int unsigned          NSYMB_WIDTH = 16,
  parameter int unsigned          REG_WIDTH   = 12,
  parameter logic [REG_WIDTH-1:0] SYNC_MASK   = REG_WIDTH'(SyncMaskDefault),
  parameter int unsigned          SYNC_MIN    = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NSIG_WIDTH-1:0]  cfg_nsig,
  input  logic [NSYMB_WIDTH-1:0] cfg_nsymb,
  input  logic [PHASE_WIDTH-1:0] cfg_ph_base,
  input  logic [PHASE_WIDTH-1:0] cfg_ph_step,
  input  logic                   cfg_continuous,
  input  logic [REG_WIDTH-1:0]   fp_gpio_in,
  output logic [REG_WIDTH-1:0]   fp_gpio_out,
  output logic [REG_WIDTH-1:0]   fp_gpio_ddr,
  tag_rx_seq_ctrl_if.master      rx
);
  localparam int unsigned QualW      = $clog2(SYNC_MIN + 2);
  localparam rx_state_e   QualTarget = (SYNC_MIN <= 1) ? StArmed : StQual;

  logic [REG_WIDTH-1:0] gpio_s1, gpio_s;
  logic                 sync, sync_ahead;

  gpio_sync #(.WIDTH(REG_WIDTH)) u_gpio_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .gpio_in (fp_gpio_in),
    .gpio_s1 (gpio_s1),
    .gpio_s  (gpio_s)
  );

  assign sync       = (gpio_s & SYNC_MASK) == SYNC_MASK;
  // First-stage value is what the FSM will see next cycle; used only to hold
  // back frame_done when that last sample is about to be aborted.
  assign sync_ahead = (gpio_s1 & SYNC_MASK) == SYNC_MASK;

  logic [NSIG_WIDTH-1:0]  cfg_nsig_eff;
  logic [NSYMB_WIDTH-1:0] cfg_nsymb_eff;
  assign cfg_nsig_eff  = (cfg_nsig == '0) ? NSIG_WIDTH'(1) : cfg_nsig;
  assign cfg_nsymb_eff = (cfg_nsymb == '0) ? NSYMB_WIDTH'(1) : cfg_nsymb;

  rx_state_e              state_q, state_d;
  logic [QualW-1:0]       qual_q, qual_d;
  logic [NSIG_WIDTH-1:0]  samp_q, samp_d, nsig_q, nsig_d;
  logic [NSYMB_WIDTH-1:0] symb_q, symb_d, nsymb_q, nsymb_d;
  logic [PHASE_WIDTH-1:0] ph_q, ph_d, phinc_q, phinc_d, step_q, step_d;
  logic                   cont_q, cont_d;
  logic                   trig_q, trig_d, run_q, run_d, done_q, done_d;
  logic                   err_q, err_d, sync_en_q, sync_en_d;
  logic                   load, last_d;

  always_comb begin
    state_d = state_q;
    qual_d  = qual_q;
    samp_d  = samp_q;
    symb_d  = symb_q;
    ph_d    = ph_q;
    phinc_d = phinc_q;
    nsig_d  = nsig_q;
    nsymb_d = nsymb_q;
    step_d  = step_q;
    cont_d  = cont_q;
    err_d   = 1'b0;
    load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sync) begin
          state_d = QualTarget;
          qual_d  = QualW'(1);
        end
      end
      StQual: begin
        if (!sync) begin
          state_d = StIdle;
          qual_d  = '0;
        end else begin
          qual_d = qual_q + QualW'(1);
          if (qual_d >= QualW'(SYNC_MIN)) state_d = StArmed;
        end
      end
      StArmed: begin
        if (!sync) begin
          state_d = StRun;
          load    = 1'b1;
        end
      end
      StRun: begin
        if (sync) begin
          state_d = QualTarget;
          qual_d  = QualW'(1);
          err_d   = 1'b1;
          samp_d  = '0;
          symb_d  = '0;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + phinc_q;
          if (samp_q == nsig_q - NSIG_WIDTH'(1)) begin
            samp_d = '0;
            if (symb_q == nsymb_q - NSYMB_WIDTH'(1)) begin
              if (cont_q) load = 1'b1;
              else        state_d = StDone;
            end else begin
              symb_d  = symb_q + NSYMB_WIDTH'(1);
              phinc_d = phinc_q + step_q;
            end
          end else begin
            samp_d = samp_q + NSIG_WIDTH'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Frame start: shadow the config so mid-frame writes wait for the next frame.
    if (load) begin
      nsig_d  = cfg_nsig_eff;
      nsymb_d = cfg_nsymb_eff;
      step_d  = cfg_ph_step;
      cont_d  = cfg_continuous;
      samp_d  = '0;
      symb_d  = '0;
      ph_d    = '0;
      phinc_d = cfg_ph_base;
    end

    run_d     = (state_d == StRun);
    last_d    = (samp_d == nsig_d - NSIG_WIDTH'(1)) && (symb_d == nsymb_d - NSYMB_WIDTH'(1));
    trig_d    = run_d && (samp_d == '0);
    done_d    = run_d && last_d && !sync_ahead;
    sync_en_d = (state_d == StQual) || (state_d == StArmed);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      qual_q    <= '0;
      samp_q    <= '0;
      symb_q    <= '0;
      ph_q      <= '0;
      phinc_q   <= '0;
      nsig_q    <= NSIG_WIDTH'(1);
      nsymb_q   <= NSYMB_WIDTH'(1);
      step_q    <= '0;
      cont_q    <= 1'b0;
      trig_q    <= 1'b0;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      sync_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      qual_q    <= qual_d;
      samp_q    <= samp_d;
      symb_q    <= symb_d;
      ph_q      <= ph_d;
      phinc_q   <= phinc_d;
      nsig_q    <= nsig_d;
      nsymb_q   <= nsymb_d;
      step_q    <= step_d;
      cont_q    <= cont_d;
      trig_q    <= trig_d;
      run_q     <= run_d;
      done_q    <= done_d;
      err_q     <= err_d;
      sync_en_q <= sync_en_d;
    end
  end

  assign rx.ph         = ph_q;
  assign rx.phinc      = phinc_q;
  assign rx.symbN      = symb_q;
  assign rx.rx_state   = state_q;
  assign rx.rx_sync_en = sync_en_q;
  assign rx.rx_trig    = trig_q;
  assign rx.rx_valid   = run_q;
  assign rx.rx_out_mux = run_q;
  assign rx.frame_done = done_q;
  assign rx.sync_err   = err_q;

  assign fp_gpio_out = {{(REG_WIDTH - 4){1'b0}}, trig_q, state_q};
  assign fp_gpio_ddr = REG_WIDTH'(FpGpioDdr);
endmodule
